// File: rtl/l2c_wb_pkg.sv
// Shared definitions for the L2C writeback arbiter: one-hot FSM encoding and
// the width of the line address handed to the MNI.
package l2c_wb_pkg;

    typedef enum logic [4:0] {
        ST_IDLE        = 5'b00001,
        ST_CHECK_SPACE = 5'b00010,
        ST_TAG         = 5'b00100,
        ST_SRAM        = 5'b01000,
        ST_ACCESS      = 5'b10000
    } wbState_e;

    // Line address = {old tag, set index bits of the SRAM address, zero line offset}.
    function automatic int wbAdrWidth(input int tagW, input int adrW,
                                      input int idxLsb, input int lineOfs);
        return tagW + adrW - idxLsb + lineOfs;
    endfunction

endpackage

// File: rtl/l2c_wb_prio_sel.sv
// N-wide priority selector. Priority starts at index base_i and wraps, so a
// base of zero gives plain fixed priority with index 0 highest.
module l2c_wb_prio_sel #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] base_i,
    input  logic             en_i,
    output logic [N-1:0]     grant_o,
    output logic             any_o
);

    logic [2*N-1:0] reqDbl;
    logic [N-1:0]   reqRot;
    logic [N-1:0]   grantRot;
    logic [2*N-1:0] grantDbl;

    // Rotate so the base index sits at bit 0, isolate the lowest set bit, rotate back.
    always_comb begin
        reqDbl   = {req_i, req_i};
        reqRot   = reqDbl[base_i +: N];
        grantRot = reqRot & (~reqRot + 1'b1);
        grantDbl = {grantRot, grantRot} << base_i;
        grant_o  = en_i ? grantDbl[2*N-1:N] : '0;
        any_o    = |req_i;
    end

endmodule

// File: rtl/l2c_wb_arbiter.sv
// L2C victim-writeback arbiter and sequencer: picks one requester, latches its
// address and tag, then walks tag-SRAM access, SRAM burst and MNI handshake.
// Define L2C_WB_RR_EN for round-robin arbitration; fixed priority otherwise.
module l2c_wb_arbiter
    import l2c_wb_pkg::*;
#(
    parameter int               N_REQ      = 4,
    parameter int               ADR_W      = 18,
    parameter int               TAG_W      = 17,
    parameter int               IDX_LSB    = 9,
    parameter int               LINE_OFS   = 6,
    parameter int               LINE_BEATS = 8,
    parameter logic [N_REQ-1:0] COMBO_MASK = 'b0100
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     i_mni_wb_space,
    input  logic [N_REQ-1:0]         i_req,
    input  logic [N_REQ*ADR_W-1:0]   i_sram_adr,
    input  logic [N_REQ*TAG_W-1:0]   i_old_tag,
    input  logic                     i_tag_ack,
    input  logic                     i_start,
    input  logic                     i_beat,
    output logic                     o_tag_sram_req,
    output logic                     o_tag_sram_combo,
    output logic [wbAdrWidth(TAG_W, ADR_W, IDX_LSB, LINE_OFS)-1:0] o_writeback_adr,
    output logic [ADR_W-1:0]         o_sram_adr,
    output logic                     o_mni_wb_valid,
    output logic [N_REQ-1:0]         o_ack,
    output logic                     o_busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_BEATS - 1);

    wbState_e          state_q, state_d;
    logic [N_REQ-1:0]  grant_q;
    logic [N_REQ-1:0]  ack_q;
    logic              valid_q;
    logic [CNT_W-1:0]  beatCnt_q;
    logic [ADR_W-1:0]  sramAdr_q;
    logic [wbAdrWidth(TAG_W, ADR_W, IDX_LSB, LINE_OFS)-1:0] wbAdr_q;

    logic [N_REQ-1:0]  selGrant;
    logic              anyReq;
    logic [IDX_W-1:0]  rotBase;
    logic [ADR_W-1:0]  selAdr;
    logic [TAG_W-1:0]  selTag;
    logic              inIdle;

    assign inIdle = (state_q == ST_IDLE);

    l2c_wb_prio_sel #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_prio_sel (
        .req_i   (i_req),
        .base_i  (rotBase),
        .en_i    (inIdle),
        .grant_o (selGrant),
        .any_o   (anyReq)
    );

`ifdef L2C_WB_RR_EN
    logic [IDX_W-1:0] rrPtr_q, rrPtr_d, ackIdx;

    // Pointer holds the first index to search; it moves past the winner on its ack.
    always_comb begin
        ackIdx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (ack_q[i]) ackIdx = IDX_W'(i);
        end
        rrPtr_d = rrPtr_q;
        if (|ack_q) begin
            rrPtr_d = (ackIdx == IDX_W'(N_REQ - 1)) ? '0 : ackIdx + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) rrPtr_q <= '0;
        else       rrPtr_q <= rrPtr_d;
    end

    assign rotBase = rrPtr_q;
`else
    assign rotBase = '0;
`endif

    always_comb begin
        selAdr = '0;
        selTag = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (selGrant[i]) begin
                selAdr = i_sram_adr[i*ADR_W +: ADR_W];
                selTag = i_old_tag[i*TAG_W +: TAG_W];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:        if (anyReq) state_d = i_mni_wb_space ? ST_TAG : ST_CHECK_SPACE;
            ST_CHECK_SPACE: if (i_mni_wb_space) state_d = ST_TAG;
            ST_TAG:         if (i_tag_ack) state_d = ST_SRAM;
            ST_SRAM:        if (i_start) state_d = ST_ACCESS;
            ST_ACCESS:      if (i_beat && (beatCnt_q == LAST_BEAT)) state_d = ST_IDLE;
            default:        state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_tag_sram_req   = (state_q == ST_TAG);
        o_tag_sram_combo = (state_q == ST_TAG) && |(grant_q & COMBO_MASK);
        o_busy           = !inIdle;
    end

    // The ack fires the cycle after the tag grant, so it lands in the first SRAM cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            grant_q   <= '0;
            ack_q     <= '0;
            valid_q   <= 1'b0;
            beatCnt_q <= '0;
        end else begin
            if (inIdle) grant_q <= selGrant;
            ack_q <= ((state_q == ST_TAG) && i_tag_ack) ? grant_q : '0;
            if (i_start)     valid_q <= 1'b1;
            else if (inIdle) valid_q <= 1'b0;
            if ((state_q == ST_SRAM) && i_start) begin
                beatCnt_q <= '0;
            end else if ((state_q == ST_ACCESS) && i_beat) begin
                beatCnt_q <= (beatCnt_q == LAST_BEAT) ? '0 : beatCnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (inIdle && anyReq) begin
            sramAdr_q <= selAdr;
            wbAdr_q   <= {selTag, selAdr[ADR_W-1:IDX_LSB], {LINE_OFS{1'b0}}};
        end
    end

    assign o_sram_adr      = sramAdr_q;
    assign o_writeback_adr = wbAdr_q;
    assign o_mni_wb_valid  = valid_q;
    assign o_ack           = ack_q;

endmodule

// File: tb/tb_l2c_wb_arbiter.sv
// Directed bench for l2c_wb_arbiter with hand-computed expected values.
// Follows the arbitration order selected by L2C_WB_RR_EN.
module tb_l2c_wb_arbiter;

    logic        Clk;
    logic        Reset;
    logic        i_mni_wb_space;
    logic [3:0]  i_req;
    logic [71:0] i_sram_adr;
    logic [67:0] i_old_tag;
    logic        i_tag_ack;
    logic        i_start;
    logic        i_beat;
    logic        o_tag_sram_req;
    logic        o_tag_sram_combo;
    logic [31:0] o_writeback_adr;
    logic [17:0] o_sram_adr;
    logic        o_mni_wb_valid;
    logic [3:0]  o_ack;
    logic        o_busy;

    int checks = 0;
    int errors = 0;

    logic [17:0] slotAdr [4];
    logic [16:0] slotTag [4];
    logic [3:0]  expAck  [4];
    int          expSlot [4];

    l2c_wb_arbiter dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .i_mni_wb_space   (i_mni_wb_space),
        .i_req            (i_req),
        .i_sram_adr       (i_sram_adr),
        .i_old_tag        (i_old_tag),
        .i_tag_ack        (i_tag_ack),
        .i_start          (i_start),
        .i_beat           (i_beat),
        .o_tag_sram_req   (o_tag_sram_req),
        .o_tag_sram_combo (o_tag_sram_combo),
        .o_writeback_adr  (o_writeback_adr),
        .o_sram_adr       (o_sram_adr),
        .o_mni_wb_valid   (o_mni_wb_valid),
        .o_ack            (o_ack),
        .o_busy           (o_busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic applyStimulus(input logic [3:0] req, input logic space,
                                 input logic tagAck, input logic start, input logic beat);
        i_req          = req;
        i_mni_wb_space = space;
        i_tag_ack      = tagAck;
        i_start        = start;
        i_beat         = beat;
        @(posedge Clk);
        #1;
    endtask

    // From Tag: grant, single-cycle ack, burst start, full line of beats, back to Idle.
    task automatic completeFromTag(input logic [3:0] reqNow, input logic [3:0] reqAfter,
                                   input logic [3:0] ackExp);
        applyStimulus(reqNow, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("ack pulse", 64'(o_ack), 64'(ackExp));
        checkOutput("tag req off in SRAM", 64'(o_tag_sram_req), 64'd0);
        applyStimulus(reqAfter, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("ack single cycle", 64'(o_ack), 64'd0);
        checkOutput("valid after start", 64'(o_mni_wb_valid), 64'd1);
        for (int i = 0; i < 7; i++) applyStimulus(reqAfter, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("busy before last beat", 64'(o_busy), 64'd1);
        applyStimulus(reqAfter, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("idle after last beat", 64'(o_busy), 64'd0);
    endtask

    initial begin
        slotAdr[0] = 18'h2A5FF; slotTag[0] = 17'h1ABCD;
        slotAdr[1] = 18'h00200; slotTag[1] = 17'h00001;
        slotAdr[2] = 18'h3FE00; slotTag[2] = 17'h1FFFF;
        slotAdr[3] = 18'h12345; slotTag[3] = 17'h0F0F0;
        for (int i = 0; i < 4; i++) begin
            i_sram_adr[i*18 +: 18] = slotAdr[i];
            i_old_tag[i*17 +: 17]  = slotTag[i];
        end
`ifdef L2C_WB_RR_EN
        expAck[0] = 4'b0010; expAck[1] = 4'b0100; expAck[2] = 4'b1000; expAck[3] = 4'b0010;
        expSlot[0] = 1; expSlot[1] = 2; expSlot[2] = 3; expSlot[3] = 1;
`else
        for (int i = 0; i < 4; i++) begin
            expAck[i]  = 4'b0010;
            expSlot[i] = 1;
        end
`endif

        Reset = 1'b1;
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        Reset = 1'b0;
        checkOutput("reset busy", 64'(o_busy), 64'd0);
        checkOutput("reset ack", 64'(o_ack), 64'd0);
        checkOutput("reset valid", 64'(o_mni_wb_valid), 64'd0);
        checkOutput("reset tag req", 64'(o_tag_sram_req), 64'd0);

        // Single requester, space available, tag grant two cycles in.
        applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("single tag req", 64'(o_tag_sram_req), 64'd1);
        checkOutput("single combo", 64'(o_tag_sram_combo), 64'd0);
        checkOutput("single sram adr", 64'(o_sram_adr), 64'(18'h2A5FF));
        checkOutput("single wb adr", 64'(o_writeback_adr), 64'({17'h1ABCD, 9'h152, 6'b0}));
        applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("single still tag", 64'(o_tag_sram_req), 64'd1);
        completeFromTag(4'b0001, 4'b0000, 4'b0001);
        checkOutput("valid held on idle entry", 64'(o_mni_wb_valid), 64'd1);
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("valid cleared in idle", 64'(o_mni_wb_valid), 64'd0);

        // No MNI space: park in CheckSpace until it rises.
        applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("nospace busy", 64'(o_busy), 64'd1);
        checkOutput("nospace sram adr", 64'(o_sram_adr), 64'(18'h3FE00));
        for (int i = 0; i < 5; i++) begin
            checkOutput("nospace tag req", 64'(o_tag_sram_req), 64'd0);
            applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        checkOutput("nospace still waiting", 64'(o_tag_sram_req), 64'd0);
        applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("space tag req", 64'(o_tag_sram_req), 64'd1);
        checkOutput("space combo", 64'(o_tag_sram_combo), 64'd1);
        checkOutput("space wb adr", 64'(o_writeback_adr), 64'({17'h1FFFF, 9'h1FF, 6'b0}));
        completeFromTag(4'b0100, 4'b0000, 4'b0100);

        // Arbitration order with requesters 1..3 held continuously.
        Reset = 1'b1;
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        Reset = 1'b0;
        for (int t = 0; t < 4; t++) begin
            applyStimulus(4'b1110, 1'b1, 1'b0, 1'b0, 1'b0);
            checkOutput("arb winner adr", 64'(o_sram_adr), 64'(slotAdr[expSlot[t]]));
            completeFromTag(4'b1110, 4'b1110, expAck[t]);
        end
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);

        // Beats in SRAM are ignored; a gap after seven beats keeps Access.
        applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("sram beats ignored", 64'(o_busy), 64'd1);
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
            checkOutput("beat gap busy", 64'(o_busy), 64'd1);
        end
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("eighth beat idle", 64'(o_busy), 64'd0);
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("start in idle wins", 64'(o_mni_wb_valid), 64'd1);
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("valid clear after idle", 64'(o_mni_wb_valid), 64'd0);

        // Reset in Access after three beats.
        applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
        Reset = 1'b1;
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
        Reset = 1'b0;
        checkOutput("abort busy", 64'(o_busy), 64'd0);
        checkOutput("abort ack", 64'(o_ack), 64'd0);
        checkOutput("abort valid", 64'(o_mni_wb_valid), 64'd0);

        // Reset in Tag alongside the tag grant: no ack for the aborted request.
        applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0, 1'b0);
        Reset = 1'b1;
        applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
        Reset = 1'b0;
        checkOutput("tag abort busy", 64'(o_busy), 64'd0);
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("tag abort no ack", 64'(o_ack), 64'd0);

        // After reset requester 0 has top priority again.
        applyStimulus(4'b1001, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("post reset winner", 64'(o_sram_adr), 64'(18'h2A5FF));
        completeFromTag(4'b1001, 4'b0000, 4'b0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
